// File: rtl/button_event_decoder_pkg.sv
// Shared constants for the button event decoder.
// Direction codes, FSM state encoding and counter width.
package button_event_decoder_pkg;

    localparam int CNT_W = 25;

    localparam logic [1:0] DIR_N = 2'd0;
    localparam logic [1:0] DIR_E = 2'd1;
    localparam logic [1:0] DIR_S = 2'd2;
    localparam logic [1:0] DIR_W = 2'd3;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_HELD   = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

endpackage

// File: rtl/button_event_decoder_sync_2ff.sv
// Two-flop synchronizer for asynchronous level inputs.
// Ports: clk, rst_n (async low), d (raw), q (synchronized).
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] s1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            q  <= '0;
        end else begin
            s1 <= d;
            q  <= s1;
        end
    end

endmodule

// File: rtl/button_event_decoder.sv
// Turns toggle-coded button presses into press/auto-repeat events.
// Ports: clk, rst_n, btn_toggle, btn_n/e/s/w, ev_valid/ready/dir/repeat, ovf.
module button_event_decoder
    import button_event_decoder_pkg::*;
#(
    parameter int REPEAT_DELAY = 25000000,
    parameter int REPEAT_RATE  = 5000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_toggle,
    input  logic       btn_north,
    input  logic       btn_east,
    input  logic       btn_south,
    input  logic       btn_west,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [1:0] ev_dir,
    output logic       ev_repeat,
    output logic       ovf
);

    localparam logic [CNT_W-1:0] DLY_LD = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LD = CNT_W'(REPEAT_RATE - 1);

    logic [4:0] raw;
    logic [4:0] syn;

    assign raw = {btn_toggle, btn_north, btn_east, btn_south, btn_west};

    sync_2ff #(.W(5)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (raw),
        .q     (syn)
    );

    logic tog_q;
    logic tog_edge;
    logic any_btn;
    logic [1:0] smp_dir;

    assign tog_edge = syn[4] ^ tog_q;
    assign any_btn  = |syn[3:0];

    always_comb begin
        smp_dir = DIR_W;
        priority case (1'b1)
            syn[3]: smp_dir = DIR_N;
            syn[2]: smp_dir = DIR_E;
            syn[1]: smp_dir = DIR_S;
            default: smp_dir = DIR_W;
        endcase
    end

    logic [1:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]       dir_q, dir_n;
    logic             armed, armed_n;
    logic             gen;
    logic             gen_rep;
    logic [1:0]       gen_dir;

    // A press with no direction button still enters HELD to keep
    // toggle parity, but stays unarmed so it never auto-repeats.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        dir_n   = dir_q;
        armed_n = armed;
        gen     = 1'b0;
        gen_rep = 1'b0;
        gen_dir = dir_q;
        case (state)
            ST_IDLE: begin
                if (tog_edge) begin
                    state_n = ST_HELD;
                    cnt_n   = DLY_LD;
                    armed_n = any_btn;
                    if (any_btn) begin
                        dir_n   = smp_dir;
                        gen     = 1'b1;
                        gen_dir = smp_dir;
                    end
                end
            end
            ST_HELD, ST_REPEAT: begin
                if (tog_edge) begin
                    state_n = ST_IDLE;
                    cnt_n   = '0;
                    armed_n = 1'b0;
                end else if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (armed) begin
                    state_n = ST_REPEAT;
                    cnt_n   = RATE_LD;
                    gen     = 1'b1;
                    gen_rep = 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
                armed_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tog_q <= 1'b0;
            state <= ST_IDLE;
            cnt   <= '0;
            dir_q <= DIR_N;
            armed <= 1'b0;
        end else begin
            tog_q <= syn[4];
            state <= state_n;
            cnt   <= cnt_n;
            dir_q <= dir_n;
            armed <= armed_n;
        end
    end

    // Single-entry event register; an event arriving while it is
    // still occupied and not being accepted is lost and flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_valid  <= 1'b0;
            ev_dir    <= DIR_N;
            ev_repeat <= 1'b0;
            ovf       <= 1'b0;
        end else if (gen) begin
            if (!ev_valid || ev_ready) begin
                ev_valid  <= 1'b1;
                ev_dir    <= gen_dir;
                ev_repeat <= gen_rep;
            end else begin
                ovf <= 1'b1;
            end
        end else if (ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_event_decoder.sv
// Self-checking bench for button_event_decoder.
// Vector table, directed corner cases and random stimulus vs a model.
module tb_button_event_decoder;

    localparam int D = 8;
    localparam int R = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tog = 1'b0;
    logic [3:0] btn = 4'b0;
    logic       rdy = 1'b1;
    logic       ev_valid;
    logic [1:0] ev_dir;
    logic       ev_repeat;
    logic       ovf;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    button_event_decoder #(.REPEAT_DELAY(D), .REPEAT_RATE(R)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .btn_toggle (tog),
        .btn_north  (btn[3]),
        .btn_east   (btn[2]),
        .btn_south  (btn[1]),
        .btn_west   (btn[0]),
        .ev_valid   (ev_valid),
        .ev_ready   (rdy),
        .ev_dir     (ev_dir),
        .ev_repeat  (ev_repeat),
        .ovf        (ovf)
    );

    // Reference model: inputs seen by the decision logic are the
    // pins from two edges ago; repeats are placed arithmetically.
    logic       h1t, h2t, h3t;
    logic [3:0] h1b, h2b;
    int         cyc;
    bit         pressed, has_dir;
    int         press_t;
    logic [1:0] mdir;
    logic       mv, mr, mo;
    logic [1:0] md;

    task automatic m_reset();
        h1t = 0; h2t = 0; h3t = 0; h1b = 0; h2b = 0;
        pressed = 0; has_dir = 0; press_t = 0; mdir = 0;
        mv = 0; mr = 0; mo = 0; md = 0;
    endtask

    task automatic m_clock();
        bit gen;
        bit grep;
        int k;
        gen = 0;
        grep = 0;
        if (h2t != h3t) begin
            if (!pressed) begin
                pressed = 1;
                press_t = cyc;
                has_dir = (h2b != 0);
                if (has_dir) begin
                    if (h2b[3]) mdir = 0;
                    else if (h2b[2]) mdir = 1;
                    else if (h2b[1]) mdir = 2;
                    else mdir = 3;
                    gen = 1;
                end
            end else begin
                pressed = 0;
                has_dir = 0;
            end
        end else if (pressed && has_dir) begin
            k = cyc - press_t;
            if (k == D || (k > D && (k - D) % R == 0)) begin
                gen = 1;
                grep = 1;
            end
        end
        if (gen) begin
            if (!mv || rdy) begin
                mv = 1; md = mdir; mr = grep;
            end else begin
                mo = 1;
            end
        end else if (mv && rdy) begin
            mv = 0;
        end
        h3t = h2t; h2t = h1t; h2b = h1b;
        h1t = tog; h1b = btn;
        cyc++;
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0d required=%0d",
                     nm, $time, act, exp);
        end
    endtask

    int evs;
    int bad_dir;

    task automatic step();
        @(posedge clk);
        if (rst_n) m_clock();
        #1;
        chk("valid", int'(ev_valid), int'(mv));
        chk("dir", int'(ev_dir), int'(md));
        chk("repeat", int'(ev_repeat), int'(mr));
        chk("ovf", int'(ovf), int'(mo));
        if (ev_valid && rdy) evs++;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        #3;
        rst_n = 0;
        tog = 0;
        m_reset();
        #1;
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_dir", int'(ev_dir), 0);
        chk("rst_rep", int'(ev_repeat), 0);
        chk("rst_ovf", int'(ovf), 0);
        steps(3);
        #2;
        rst_n = 1;
    endtask

    typedef struct {
        logic       t;
        logic [3:0] b;
        logic       r;
        logic       v;
        logic [1:0] d;
        logic       rp;
        logic       o;
    } vec_t;

    vec_t tbl[13];

    initial begin
        for (int i = 0; i < 13; i++)
            tbl[i] = '{1'b1, 4'b0100, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0};
        tbl[0].t = 1'b0;
        tbl[3].v = 1'b1; tbl[3].d = 2'd1;
        for (int i = 4; i < 13; i++) tbl[i].d = 2'd1;
        tbl[11].v = 1'b1; tbl[11].rp = 1'b1;
        tbl[12].rp = 1'b1;

        m_reset();
        cyc = 0;
        do_reset();

        // East press: event 3 edges after the toggle, repeat at +8
        foreach (tbl[i]) begin
            tog = tbl[i].t; btn = tbl[i].b; rdy = tbl[i].r;
            step();
            chk("tbl_v", int'(ev_valid), int'(tbl[i].v));
            chk("tbl_d", int'(ev_dir), int'(tbl[i].d));
            chk("tbl_r", int'(ev_repeat), int'(tbl[i].rp));
            chk("tbl_o", int'(ovf), int'(tbl[i].o));
        end
        tog = 0;
        steps(10);

        // N+W held 20 cycles: press, +8, +12, +16; +20 lost to release
        btn = 4'b1001; tog = 1; evs = 0;
        steps(20);
        tog = 0;
        steps(25);
        chk("nw_events", evs, 4);

        // Backpressure across press and first repeat
        btn = 4'b0100; rdy = 0; tog = 1;
        steps(15);
        chk("bp_valid", int'(ev_valid), 1);
        chk("bp_rep", int'(ev_repeat), 0);
        chk("bp_ovf", int'(ovf), 1);
        rdy = 1; tog = 0;
        steps(12);
        chk("ovf_sticky", int'(ovf), 1);
        do_reset();

        // Press with no direction, release, then south press
        btn = 0; tog = 1; evs = 0;
        steps(16);
        tog = 0;
        steps(10);
        chk("nodir_events", evs, 0);
        btn = 4'b0010; tog = 1;
        steps(3);
        chk("s_valid", int'(ev_valid), 1);
        chk("s_dir", int'(ev_dir), 2);
        tog = 0;
        steps(10);

        // Reset in REPEAT with an event pending
        btn = 4'b0001; rdy = 0; tog = 1;
        steps(14);
        chk("pre_rst_valid", int'(ev_valid), 1);
        do_reset();
        rdy = 1; evs = 0;
        steps(20);
        chk("post_rst_events", evs, 0);

        // Release edge lands on the same cycle as expiry
        btn = 4'b0100; tog = 1; evs = 0;
        steps(8);
        tog = 0;
        steps(25);
        chk("clash_events", evs, 1);

        // Random segments of press/release with random ready
        for (int s = 0; s < 120; s++) begin
            int len;
            len = int'($urandom_range(1, 30));
            btn = 4'($urandom);
            if ($urandom_range(0, 3) == 0) btn = 0;
            tog = ~tog;
            for (int c = 0; c < len; c++) begin
                rdy = ($urandom_range(0, 3) != 0);
                step();
            end
            if (s == 60) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/button_event_decoder.md
BUTTON_EVENT_DECODER -- requirements
Module: button_event_decoder

Interface
REQ-001 The block SHALL have parameter REPEAT_DELAY, default 25000000, meaning the clocks a press is held before the first auto-repeat (0.5 s at 50 MHz).
REQ-002 The block SHALL have parameter REPEAT_RATE, default 5000000, meaning the clocks between auto-repeats after the first.
REQ-003 Port clk  input  1  is the single clock; all logic is on its rising edge.
REQ-004 Port rst_n  input  1  is the reset; it is asynchronous and active-low.
REQ-005 Port btn_toggle  input  1  is the debounced toggle level; it inverts once per stable press or release and is 0 at power-up.
REQ-006 Ports btn_north, btn_east, btn_south, btn_west  input  1 each  are the raw asynchronous button levels, used only to identify the direction.
REQ-007 Port ev_valid  output  1  means an event is held for the consumer.
REQ-008 Port ev_ready  input  1  means the consumer accepts the event this cycle.
REQ-009 Port ev_dir  output  2  is the direction code of the held event.
REQ-010 Port ev_repeat  output  1  is 1 when the held event is an auto-repeat and 0 when it is a first press.
REQ-011 Port ovf  output  1  is a sticky flag set when an event is lost because the event register is occupied.

Function
REQ-012 The block SHALL pass btn_toggle and the four raw buttons through 2-flop synchronizers, giving 2 cycles of input latency.
REQ-013 The block SHALL detect a toggle edge when the synchronized btn_toggle differs from its registered copy.
REQ-014 The FSM states SHALL be IDLE, HELD and REPEAT; the reset state is IDLE.
REQ-015 IDLE + toggle edge: the block SHALL sample direction with priority N>E>S>W (codes N=0, E=1, S=2, W=3), generate a press event, load the counter with REPEAT_DELAY-1 and go to HELD.
REQ-016 IDLE + toggle edge with no synchronized raw button high: the block SHALL generate no event, load no direction and still go to HELD, so that press/release parity is kept.
REQ-017 HELD or REPEAT + toggle edge (release): the block SHALL go to IDLE and clear the counter, with no event.
REQ-018 HELD with counter at 0: the block SHALL generate a repeat event with the latched direction, load REPEAT_RATE-1 and go to REPEAT.
REQ-019 REPEAT with counter at 0: the block SHALL generate a repeat event, reload REPEAT_RATE-1 and stay in REPEAT.
REQ-020 The counter SHALL be 25 bits wide, decrement by 1 per cycle in HELD/REPEAT, and never wrap below 0.
REQ-021 A generated event SHALL appear on ev_valid/ev_dir/ev_repeat on the next clock edge.
REQ-022 The consumer handshake SHALL be valid/ready: the event is held stable until a cycle with ev_valid=1 and ev_ready=1, after which ev_valid clears on the next edge unless a new event is loaded.
REQ-023 Accept and a new event in the same cycle: the new event SHALL load and ev_valid SHALL stay 1.
REQ-024 A new event while ev_valid=1 and ev_ready=0: the new event SHALL be dropped, the held event kept, and ovf set to 1.
REQ-025 ovf SHALL clear only on reset.
REQ-026 A release edge and a counter expiry in the same cycle: the release SHALL win and no repeat event is generated.

Reset
REQ-027 While rst_n=0 the block SHALL hold state=IDLE, counter=0, ev_valid=0, ev_dir=0, ev_repeat=0, ovf=0, and all synchronizer and edge registers at 0.
REQ-028 Reset asserted mid-hold SHALL discard the held event and parity; after release, btn_toggle parity is assumed released (0).

Structure
REQ-029 A shared package SHALL hold the direction codes DIR_N/E/S/W, the FSM state encoding and the counter width constant.
REQ-030 The 2-flop synchronizer SHALL be a sub-module named sync_2ff with 5 instances or one 5-bit instance.

Verification (REPEAT_DELAY=8, REPEAT_RATE=4)
REQ-031 East held, toggle 0->1 with ev_ready=1 -> one ev_valid pulse with ev_dir=1 and ev_repeat=0, 3 cycles after the toggle edge.
REQ-032 North and west held, toggle 0->1, hold 20 cycles, then toggle 1->0 -> press event (dir 0), repeat at +8, then +12, +16, +20 clamped by the release; no event after the release edge.
REQ-033 ev_ready=0 through the press and the first repeat -> ev_valid stays 1 with ev_repeat=0 and ovf=1.
REQ-034 Toggle 0->1 with no raw button high -> no event; the next toggle 1->0 -> no event; the following press with south held -> event with dir 2.
REQ-035 rst_n pulled low in REPEAT with an event pending -> all outputs 0 at once; no events until the next toggle edge.
REQ-036 Release edge on the same cycle as counter=0 -> no repeat event and state IDLE.
